// File: rtl/frame_tx_scheduler.sv
// Round-robin frame scheduler: serializes {header, payload} frames onto a 1-bit stream, idle frames when starved.
// Optional build macro FRAME_TX_SCHEDULER_CH0_PRIO_EN gives channel 0 strict priority over the round-robin set.
module frame_tx_scheduler #(
    parameter int NUM_CH    = 2,
    parameter int HDR_W     = 6,
    parameter int PAYLOAD_W = 96,
    localparam int FRAME_W  = HDR_W + PAYLOAD_W,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   in_data,
    output logic [NUM_CH-1:0]             in_ready,
    output logic                          out_valid,
    output logic                          out_data,
    input  logic                          out_ready,
    output logic [CH_W-1:0]               cur_ch,
    output logic                          cur_idle
);
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int RR_N  = (NUM_CH > 1) ? NUM_CH - 1 : 1;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = {{HDR_W{1'b1}}, {(PAYLOAD_W/4){4'b0011}}};

    typedef enum logic {ST_LOAD, ST_TX} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_W-1:0]   sr;
    logic [CH_W-1:0]      ptr;
    logic [CH_W-1:0]      gnt_idx;
    logic [PAYLOAD_W-1:0] gnt_data;
    logic                 gnt_hit;
    logic                 ptr_upd;
    logic                 load;

    // A frame is (re)loaded after reset and on the handshake of the last bit.
    assign load = !rst && ((state == ST_LOAD) ||
                           (out_ready && cnt == CNT_W'(FRAME_W - 1)));

    // Winner is the valid channel at the smallest circular distance past the pointer.
    always_comb begin
        int best;
        int d;
        gnt_hit  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        ptr_upd  = 1'b0;
        best     = NUM_CH;
        d        = 0;
`ifdef FRAME_TX_SCHEDULER_CH0_PRIO_EN
        for (int c = 1; c < NUM_CH; c++) begin
            d = (c - int'(ptr) - 1 + 2 * RR_N) % RR_N;
            if (in_valid[c] && d < best) begin
                best     = d;
                gnt_hit  = 1'b1;
                gnt_idx  = CH_W'(c);
                gnt_data = in_data[c*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        ptr_upd = gnt_hit;
        if (in_valid[0]) begin
            gnt_hit  = 1'b1;
            gnt_idx  = '0;
            gnt_data = in_data[0 +: PAYLOAD_W];
            ptr_upd  = 1'b0;
        end
`else
        for (int c = 0; c < NUM_CH; c++) begin
            d = (c - int'(ptr) - 1 + 2 * NUM_CH) % NUM_CH;
            if (in_valid[c] && d < best) begin
                best     = d;
                gnt_hit  = 1'b1;
                gnt_idx  = CH_W'(c);
                gnt_data = in_data[c*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        ptr_upd = gnt_hit;
`endif
        if (RR_N == 0) ptr_upd = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            sr       <= '0;
            ptr      <= CH_W'(NUM_CH - 1);
            cur_ch   <= '0;
            cur_idle <= 1'b1;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt <= '0;
                if (gnt_hit) begin
                    sr       <= {HDR_W'(gnt_idx), gnt_data};
                    cur_ch   <= gnt_idx;
                    cur_idle <= 1'b0;
                end else begin
                    sr       <= IDLE_FRAME;
                    cur_ch   <= '0;
                    cur_idle <= 1'b1;
                end
                if (ptr_upd) ptr <= gnt_idx;
            end else if (state == ST_TX && out_ready) begin
                sr  <= {sr[FRAME_W-2:0], 1'b0};
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: state_nxt = ST_TX;
            ST_TX:   state_nxt = ST_TX;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_TX);
        out_data  = sr[FRAME_W-1];
        for (int c = 0; c < NUM_CH; c++)
            in_ready[c] = load && gnt_hit && (gnt_idx == CH_W'(c));
    end
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Randomized bench for frame_tx_scheduler against a frame-level reference model (bit index, grant order).
module tb_frame_tx_scheduler;
    localparam int NUM_CH    = 2;
    localparam int HDR_W     = 6;
    localparam int PAYLOAD_W = 96;
    localparam int FRAME_W   = HDR_W + PAYLOAD_W;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_CH-1:0]           in_valid = '0;
    logic [NUM_CH*PAYLOAD_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]           in_ready;
    logic                        out_valid;
    logic                        out_data;
    logic                        out_ready = 1'b1;
    logic [CH_W-1:0]             cur_ch;
    logic                        cur_idle;

    frame_tx_scheduler #(.NUM_CH(NUM_CH), .HDR_W(HDR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cur_ch(cur_ch), .cur_idle(cur_idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs
    int vpct [NUM_CH];
    int rpct   = 100;
    bit a5     = 1'b0;
    bit rst_req = 1'b1;

    // reference model state
    bit                 m_load = 1'b1;
    int                 m_idx  = 0;
    logic [FRAME_W-1:0] m_frame = '0;
    int                 m_ptr  = NUM_CH - 1;
    int                 m_ch   = 0;
    bit                 m_idle = 1'b1;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Next winner after pointer p, or -1 when nobody asks.
    function automatic int pick(logic [NUM_CH-1:0] v, int p);
`ifdef FRAME_TX_SCHEDULER_CH0_PRIO_EN
        if (v[0]) return 0;
        for (int i = 1; i < NUM_CH; i++) begin
            int c = ((p - 1 + i) % (NUM_CH - 1)) + 1;
            if (v[c]) return c;
        end
`else
        for (int i = 1; i <= NUM_CH; i++) begin
            int c = (p + i) % NUM_CH;
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic logic [FRAME_W-1:0] idle_frame();
        logic [FRAME_W-1:0] f;
        for (int j = 0; j < FRAME_W; j++)
            f[FRAME_W-1-j] = (j < HDR_W) ? 1'b1 : (((j - HDR_W) % 4) >= 2);
        return f;
    endfunction

    task automatic step();
        int w;
        bit bnd;
        logic [NUM_CH-1:0] exp_rdy;
        #1;
        chk("out_valid", out_valid, !m_load);
        if (m_load) chk("out_data_rst", out_data, 1'b0);
        else        chk("out_data", out_data, m_frame[FRAME_W-1-m_idx]);
        chk("cur_ch", cur_ch, m_ch);
        chk("cur_idle", cur_idle, m_idle);
        bnd = !rst && (m_load || (out_ready && m_idx == FRAME_W - 1));
        w = bnd ? pick(in_valid, m_ptr) : -1;
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        if (rst) begin
            m_load = 1'b1; m_idx = 0; m_frame = '0; m_ptr = NUM_CH - 1; m_ch = 0; m_idle = 1'b1;
        end else if (bnd) begin
            if (w >= 0) begin
                m_frame = {HDR_W'(w), in_data[w*PAYLOAD_W +: PAYLOAD_W]};
                m_ch = w; m_idle = 1'b0;
`ifdef FRAME_TX_SCHEDULER_CH0_PRIO_EN
                if (w != 0) m_ptr = w;
`else
                m_ptr = w;
`endif
            end else begin
                m_frame = idle_frame(); m_ch = 0; m_idle = 1'b1;
            end
            m_idx = 0; m_load = 1'b0;
        end else if (out_ready) begin
            m_idx++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rst = rst_req;
        for (int c = 0; c < NUM_CH; c++) begin
            in_valid[c] = ($urandom_range(99) < vpct[c]);
            in_data[c*PAYLOAD_W +: PAYLOAD_W] = (a5 && c == 0) ? {(PAYLOAD_W/8){8'hA5}}
                                                : {$urandom, $urandom, $urandom};
        end
        out_ready = ($urandom_range(99) < rpct);
        step();
    endtask

    initial begin
        bit found;
        for (int c = 0; c < NUM_CH; c++) vpct[c] = 0;
        // reset, then idle frames back-to-back
        rst_req = 1'b1;
        repeat (3) cyc();
        rst_req = 1'b0;
        repeat (2 * FRAME_W + 5) cyc();

        // single ch0 word with A5 payload, then idle again
        a5 = 1'b1; vpct[0] = 100;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME_W && !found; i++) begin
            cyc();
            if (!m_idle && m_ch == 0 && m_idx == 0) found = 1'b1;
        end
        chk("ch0_granted", found, 1'b1);
        vpct[0] = 0;
        repeat (2 * FRAME_W + 3) cyc();
        a5 = 1'b0;

        // all channels continuously valid
        for (int c = 0; c < NUM_CH; c++) vpct[c] = 100;
        repeat (4 * FRAME_W) cyc();

        // random valids with ~30% backpressure
        for (int c = 0; c < NUM_CH; c++) vpct[c] = 50;
        rpct = 70;
        repeat (1200) cyc();

        // reset in the middle of a ch1 frame
        for (int c = 0; c < NUM_CH; c++) vpct[c] = 100;
        rpct = 100;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME_W && !found; i++) begin
            cyc();
            if (!m_idle && m_ch == 1 && m_idx == 50) found = 1'b1;
        end
        chk("ch1_bit50", found, 1'b1);
        rst_req = 1'b1;
        cyc();
        rst_req = 1'b0;
        cyc();
        cyc();
        chk("post_rst_grant_ch", cur_ch, 0);
        chk("post_rst_grant_real", cur_idle, 1'b0);
        repeat (3 * FRAME_W) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
